// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port synchronous dmem between requester 0 (CPU) and
// requester 1 (debug/DMA). Grants are combinational, the winning command is registered
// onto the dmem port and read data returns to its owner two cycles after the grant.
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration; otherwise
// requester 0 has fixed priority on contention.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_wren_o,
  input  logic [DATA_W-1:0] mem_q_i
);

  typedef struct packed {
    logic valid;
    logic is_read;
    logic owner;  // 0 = requester 0, 1 = requester 1
  } pipe_t;

  logic              win1;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_wren_q, mem_wren_d;
  pipe_t             issue_q, issue_d;   // command on the dmem port this cycle
  pipe_t             ret_q;              // command whose read data is on mem_q_i
  logic [DATA_W-1:0] hold0_q, hold0_d;
  logic [DATA_W-1:0] hold1_q, hold1_d;

`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;  // last winner; reset to 1 so requester 0 is favoured first

  // Round-robin: on contention the requester that did not win last time goes first.
  always_comb begin
    win1   = req1_i & (~req0_i | ~last_q);
    last_d = last_q;
    if (accept) begin
      last_d = win1;
    end
  end

  // Pointer moves only when something is granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: requester 0 always wins contention.
  assign win1 = req1_i & ~req0_i;
`endif

  // Grants are forced low while reset is asserted.
  always_comb begin
    gnt0_o = rst_ni & req0_i & ~win1;
    gnt1_o = rst_ni & win1;
    accept = gnt0_o | gnt1_o;
  end

  // Select the winning command and form the next issue-stage contents.
  always_comb begin
    sel_we    = win1 ? we1_i    : we0_i;
    sel_addr  = win1 ? addr1_i  : addr0_i;
    sel_wdata = win1 ? wdata1_i : wdata0_i;

    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_wren_d    = 1'b0;
    issue_d       = '0;
    if (accept) begin
      mem_address_d   = sel_addr;
      mem_data_d      = sel_wdata;
      mem_wren_d      = sel_we;
      issue_d.valid   = 1'b1;
      issue_d.is_read = ~sel_we;
      issue_d.owner   = win1;
    end
  end

  // Return-stage decode; rdata follows mem_q while valid and otherwise holds.
  always_comb begin
    rvalid0_o = ret_q.valid & ret_q.is_read & ~ret_q.owner;
    rvalid1_o = ret_q.valid & ret_q.is_read & ret_q.owner;
    hold0_d   = rvalid0_o ? mem_q_i : hold0_q;
    hold1_d   = rvalid1_o ? mem_q_i : hold1_q;
    rdata0_o  = hold0_d;
    rdata1_o  = hold1_d;
  end

  // Command register, owner pipeline and read-data hold registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      issue_q       <= '0;
      ret_q         <= '0;
      hold0_q       <= '0;
      hold1_q       <= '0;
    end else begin
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
      issue_q       <= issue_d;
      ret_q         <= issue_q;
      hold0_q       <= hold0_d;
      hold1_q       <= hold1_d;
    end
  end

  assign mem_address_o = mem_address_q;
  assign mem_data_o    = mem_data_q;
  assign mem_wren_o    = mem_wren_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port synchronous data memory between the processor (requester 0) and a second master such as a debug/loader or DMA port (requester 1). Runs on the same clock as the dmem (`dmem_clock` domain). Accepts at most one request per cycle, registers the winning command onto the dmem port, and routes the read data back to the owner with a fixed two-cycle latency.

## Interface
- `ADDR_W`, 12, dmem word-address width
- `DATA_W`, 32, dmem data width

- `clock`  in  1  dmem-domain clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low (asserted when 0); clears all state immediately
- `req0`, `req1`  in  1  request valid, held until granted
- `we0`, `we1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  ADDR_W  word address
- `wdata0`, `wdata1`  in  DATA_W  write data
- `gnt0`, `gnt1`  out  1  combinational; request accepted this cycle
- `rvalid0`, `rvalid1`  out  1  registered; read data valid this cycle
- `rdata0`, `rdata1`  out  DATA_W  read data, valid with `rvalid`
- `mem_address`  out  ADDR_W  registered to dmem `address`
- `mem_data`  out  DATA_W  registered to dmem `data`
- `mem_wren`  out  1  registered to dmem `wren`
- `mem_q`  in  DATA_W  dmem `q`, valid one cycle after address is sampled

## Operation
- Accept stage (cycle N): if exactly one `req` high, grant it; if both high, winner per arbitration policy (see Configuration). At most one `gnt` high per cycle; `gnt` is 0 whenever corresponding `req` is 0.
- Issue stage (cycle N+1): `mem_address/mem_data/mem_wren` hold the accepted command. No accept in N → `mem_wren`=0, address/data hold previous values.
- Return stage (cycle N+2): for an accepted read, `rvalid<owner>`=1 and `rdata<owner>`=`mem_q`. Writes never raise `rvalid`.
- Owner tracking: 2-entry shift pipeline of {valid, is_read, owner}; one entry per accepted command.
- Back-to-back: a new request may be accepted every cycle by either requester; pipeline never stalls; interleaved reads from both requesters return in acceptance order.
- Read after write to same address, accepted in consecutive cycles: read returns the newly written data (dmem is write-first on the issue edge; no forwarding logic in this block).
- Requester holds `we/addr/wdata` stable while `req`=1 and `gnt`=0; values captured only on the granting edge.
- Reset (any time, including mid-operation): pipeline cleared, in-flight reads discarded, no `rvalid` emitted for them after release.

## Timing
- Reset values: `gnt0/1`=0 (forced while reset asserted), `rvalid0/1`=0, `rdata0/1`=0, `mem_wren`=0, `mem_address`=0, `mem_data`=0, priority pointer = requester 0 favoured.
- Grant latency: 0 cycles (same cycle as `req` when won).
- Read latency: `rvalid` exactly 2 cycles after the granting edge cycle.
- Write commit: dmem written on edge ending cycle N+1.
- Throughput: 1 access/cycle aggregate.
- `rdata` holds last returned value when `rvalid`=0.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. 1-bit pointer records last winner; on contention the other requester wins; pointer updates only on a grant. Guarantees a waiting requester is granted within 2 cycles.
- Not defined: fixed priority, requester 0 always wins contention; requester 1 may starve while `req0` stays high. Pointer logic omitted.

## Test plan
- Reset: hold `reset`=0 with `req0`=`req1`=1 → all outputs 0, no grants; release → first grant to requester 0.
- Single read: `req0`=1, `we0`=0, `addr0`=0x010 at cycle N → `gnt0`=1 in N, `mem_address`=0x010/`mem_wren`=0 in N+1, `rvalid0`=1 with preloaded 0xDEADBEEF in N+2, `rvalid1`=0.
- Write then read: requester 1 writes 0x12345678 to 0x0FF, next cycle reads 0x0FF → `rvalid1`=1 with 0x12345678 two cycles after the read grant.
- Contention, both continuously requesting reads: with `DMEM_ARB_RR_EN` grants alternate 0,1,0,1 and `rvalid` alternates accordingly; without it only `gnt0` asserts.
- Interleaved reads from 0 (addr 0x001) then 1 (addr 0x002) in consecutive cycles → `rvalid0` with mem[0x001] then `rvalid1` with mem[0x002] on consecutive cycles, never crossed.
- Reset mid-read: assert `reset`=0 the cycle after a read grant → no `rvalid` ever appears for that read; `mem_wren`=0.
